// File: rtl/floppy_pkg.sv
// Shared register map, bit positions and status packing for the floppy stopwatch.
package floppy_pkg;

  localparam logic [1:0] SW_CTRL_LO = 2'd0;
  localparam logic [1:0] SW_HI      = 2'd1;
  localparam logic [1:0] SW_STAT    = 2'd2;
  localparam logic [1:0] SW_CMP_LO  = 2'd3;

  localparam int unsigned SW_RUN = 0;
  localparam int unsigned SW_CLR = 1;

  localparam int unsigned SW_ST_RUN = 0;
  localparam int unsigned SW_ST_OVF = 1;
  localparam int unsigned SW_ST_IRQ = 2;

  localparam logic [15:0] SW_CNT_MAX = 16'hFFFF;

  function automatic logic [7:0] sw_status(input logic irq_pend, input logic ovf,
                                           input logic run);
    logic [7:0] s;
    s            = 8'h00;
    s[SW_ST_RUN] = run;
    s[SW_ST_OVF] = ovf;
    s[SW_ST_IRQ] = irq_pend;
    return s;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by PERIOD: one-cycle tick after PERIOD enabled clocks, held at reload when idle.
module tick_prescaler #(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned Width = $clog2(PERIOD);
  localparam logic [Width-1:0] Reload = Width'(PERIOD - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  // A restart suppresses the tick so a clear always wins over a coincident count.
  assign tick = en && !restart && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (restart || !en || (cnt_q == '0)) begin
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/floppy_stopwatch.sv
// Saturating 16-bit elapsed-tick counter with coherent LO/HI byte reads on the floppy CPU bus.
// Define FLOPPY_STOPWATCH_IRQ_EN for the compare register and level irq output.
module floppy_stopwatch
  import floppy_pkg::*;
#(
  parameter int unsigned MCLKFREQ = 24000000,
  parameter int unsigned TICKHZ   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic [7:0] di,
  input  logic       wren,
  input  logic       rden,
  output logic [7:0] q
`ifdef FLOPPY_STOPWATCH_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int unsigned Period = MCLKFREQ / TICKHZ;

  logic        run_q, run_d;
  logic        ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  q_q, q_d;
  logic        ctrl_wr, clr, tick;
  logic        irq_pend;
  logic [7:0]  cmp_lo;

  assign q       = q_q;
  assign ctrl_wr = wren && (addr == SW_CTRL_LO);
  assign clr     = ctrl_wr && di[SW_CLR];

  tick_prescaler #(
    .PERIOD(Period)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (run_q),
    .restart(clr),
    .tick   (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    run_d = run_q;
    if (tick) begin
      if (cnt_q == SW_CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    if (ctrl_wr) begin
      run_d = di[SW_RUN];
    end
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  // Reads sample pre-edge state; the LO read latches the HI byte so the pair is coherent.
  always_comb begin
    q_d  = q_q;
    hi_d = hi_q;
    if (rden) begin
      unique case (addr)
        SW_CTRL_LO: begin
          q_d  = cnt_q[7:0];
          hi_d = cnt_q[15:8];
        end
        SW_HI:     q_d = hi_q;
        SW_STAT:   q_d = sw_status(irq_pend, ovf_q, run_q);
        SW_CMP_LO: q_d = cmp_lo;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      q_q   <= '0;
    end else begin
      run_q <= run_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      q_q   <= q_d;
    end
  end

`ifdef FLOPPY_STOPWATCH_IRQ_EN
  logic [15:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;
  logic        hit;

  // Only a tick that actually advances the count can match; a saturated tick cannot.
  assign hit = tick && (cnt_q != SW_CNT_MAX) && ((cnt_q + 16'd1) == cmp_q);

  always_comb begin
    cmp_d = cmp_q;
    irq_d = irq_q;
    if (wren && (addr == SW_HI)) begin
      cmp_d[15:8] = di;
    end
    if (wren && (addr == SW_CMP_LO)) begin
      cmp_d[7:0] = di;
    end
    if (clr || (rden && (addr == SW_STAT))) begin
      irq_d = 1'b0;
    end
    if (hit) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_q <= 16'hFFFF;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end
  end

  assign irq_pend = irq_q;
  assign irq      = irq_q;
  assign cmp_lo   = cmp_q[7:0];
`else
  logic unused_di;
  assign unused_di = ^di[7:2];
  assign irq_pend  = 1'b0;
  assign cmp_lo    = 8'h00;
`endif

endmodule
